mux_src_ctrl: RTL and testbench

- Upstream source stage for the 4-bit 2:1 data-path mux.
- Debounces two raw board buttons and produces three mux inputs: the select line `ctrl` and the two 4-bit operands `A` and `B`.
- `btn_sel` toggles which operand is routed.
- `btn_inc` steps the currently routed operand up or down, so the mux output always shows the value being edited.

---
 rtl/mux_src_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mux_src_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_src_ctrl.sv
// mux_src_ctrl: button front end for the 4-bit 2:1 data-path mux.
// Two raw buttons are synchronized and debounced. btn_sel flips the mux select.
// btn_inc steps the operand that is currently routed, so the mux output always
// shows the value being edited.
// Optional build macro MUX_SRC_AUTO_STEP_EN: while btn_inc is held, the step
// repeats after HOLD_LIMIT cycles and then every REPEAT_LIMIT cycles.

`timescale 1ns/1ps

// One debounce lane: 2-flop synchronizer feeding a 4-state qualify FSM.
module mux_src_db #(
    parameter int DB_LIMIT = 1000000,
    parameter int DB_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic held,
    output logic press
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

    localparam logic [DB_W-1:0] LIM = DB_W'(DB_LIMIT - 1);

    logic [1:0]      sync_q;
    logic            s;
    db_state_t       state, nstate;
    logic [DB_W-1:0] cnt, ncnt;

    assign s = sync_q[1];

    // Metastability guard: the FSM only ever looks at the second flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], btn};
    end

    // Next state: a level must hold for DB_LIMIT cycles on both press and release.
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        case (state)
            IDLE: begin
                if (s) begin
                    nstate = PRESS_WAIT;
                    ncnt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s)             nstate = IDLE;
                else if (cnt == LIM) nstate = HELD;
                else                ncnt   = cnt + 1'b1;
            end
            HELD: begin
                if (!s) begin
                    nstate = RELEASE_WAIT;
                    ncnt   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high during release returns to HELD silently.
                if (s)               nstate = HELD;
                else if (cnt == LIM) nstate = IDLE;
                else                 ncnt   = cnt + 1'b1;
            end
            default: nstate = IDLE;
        endcase
    end

    // State/counter register plus the registered one-shot on a qualified press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            press <= (state == PRESS_WAIT) && (nstate == HELD);
        end
    end

    assign held = (state == HELD);
endmodule

module mux_src_ctrl #(
    parameter int DB_LIMIT     = 1000000,
    parameter int DB_W         = 20,
    parameter int HOLD_LIMIT   = 50000000,
    parameter int REPEAT_LIMIT = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       sw_dir,
    output logic       ctrl,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       sel_pulse,
    output logic       inc_pulse
);
    localparam int NUM_BTN = 2;
    localparam int SEL     = 0;
    localparam int INC     = 1;

    // Elaboration-time parameter sanity.
    if (DB_LIMIT < 2) begin : g_chk_db
        $error("DB_LIMIT must be >= 2");
    end
    if ((64'd1 << DB_W) <= 64'(DB_LIMIT)) begin : g_chk_w
        $error("DB_W too narrow for DB_LIMIT");
    end
    if (HOLD_LIMIT < 1 || REPEAT_LIMIT < 1) begin : g_chk_rep
        $error("HOLD_LIMIT and REPEAT_LIMIT must be >= 1");
    end

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] held;
    logic [NUM_BTN-1:0] press;
    logic               step;
    logic               unused_held;

    assign btn_raw = {btn_inc, btn_sel};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
        mux_src_db #(
            .DB_LIMIT (DB_LIMIT),
            .DB_W     (DB_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[g]),
            .held  (held[g]),
            .press (press[g])
        );
    end

`ifdef MUX_SRC_AUTO_STEP_EN
    localparam int HMAX = (HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_LIMIT - 1);
    localparam logic [HW-1:0] REP_LIM  = HW'(REPEAT_LIMIT - 1);

    logic [HW-1:0] hold_cnt;
    logic          rep_mode;
    logic          rep_q;
    logic [HW-1:0] hold_lim;

    // First wait is HOLD_LIMIT, every later wait is REPEAT_LIMIT.
    assign hold_lim = rep_mode ? REP_LIM : HOLD_LIM;

    // Hold timer runs only while the inc lane sits in HELD; leaving HELD clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            rep_mode <= 1'b0;
            rep_q    <= 1'b0;
        end else if (!held[INC]) begin
            hold_cnt <= '0;
            rep_mode <= 1'b0;
            rep_q    <= 1'b0;
        end else if (hold_cnt == hold_lim) begin
            hold_cnt <= '0;
            rep_mode <= 1'b1;
            rep_q    <= 1'b1;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
            rep_q    <= 1'b0;
        end
    end

    assign step = press[INC] | rep_q;
`else
    assign step = press[INC];
`endif

    // HELD levels only matter to the optional repeat timer.
    assign unused_held = ^held;

    // Operand/select update: the step targets the operand selected before any toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= 1'b0;
            A    <= 4'd0;
            B    <= 4'd0;
        end else begin
            if (press[SEL]) ctrl <= ~ctrl;
            if (step) begin
                if (ctrl) B <= sw_dir ? B - 4'd1 : B + 4'd1;
                else      A <= sw_dir ? A - 4'd1 : A + 4'd1;
            end
        end
    end

    assign sel_pulse = press[SEL];
    assign inc_pulse = step;
endmodule

// File: tb/tb_mux_src_ctrl.sv
// Directed bench for mux_src_ctrl with short debounce/hold limits.
// Expected values are hand-computed; the repeat count depends on whether
// MUX_SRC_AUTO_STEP_EN is defined for the build.

`timescale 1ns/1ps

module tb_mux_src_ctrl;
    localparam int DBL = 4;
    localparam int DBW = 3;
    localparam int HLD = 20;
    localparam int REP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sw_dir = 1'b0;
    logic       ctrl;
    logic [3:0] A, B;
    logic       sel_pulse, inc_pulse;

    int errs = 0;
    int checks = 0;
    int n_inc, n_sel, n_both, first_inc, ed;

    mux_src_ctrl #(
        .DB_LIMIT     (DBL),
        .DB_W         (DBW),
        .HOLD_LIMIT   (HLD),
        .REPEAT_LIMIT (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .sw_dir    (sw_dir),
        .ctrl      (ctrl),
        .A         (A),
        .B         (B),
        .sel_pulse (sel_pulse),
        .inc_pulse (inc_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_inc = 0; n_sel = 0; n_both = 0; first_inc = -1; ed = 0;
    endtask

    // One clock; outputs sampled 1 ns after the edge, pulses tallied.
    task automatic tick();
        @(posedge clk);
        #1;
        ed++;
        if (inc_pulse) begin
            n_inc++;
            if (first_inc < 0) first_inc = ed;
        end
        if (sel_pulse) n_sel++;
        if (inc_pulse && sel_pulse) n_both++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_inc(input int hi);
        btn_inc = 1'b1; ticks(hi);
        btn_inc = 1'b0; ticks(12);
    endtask

    task automatic press_sel(input int hi);
        btn_sel = 1'b1; ticks(hi);
        btn_sel = 1'b0; ticks(12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        clr();
        ticks(3);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_sel_pulse", sel_pulse, 0);
        chk("rst_inc_pulse", inc_pulse, 0);

        // Reset mid-PRESS_WAIT, button dropped as reset releases
        rst_n = 1'b1; ticks(2);
        btn_inc = 1'b1; ticks(4);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_A", A, 0);
        btn_inc = 1'b0;
        #1 rst_n = 1'b1;
        clr(); ticks(14);
        chk("rst_mid_no_inc", n_inc, 0);
        chk("rst_mid_A_after", A, 0);

        // Glitch of exactly DB_LIMIT cycles must be rejected
        clr(); btn_inc = 1'b1; ticks(DBL); btn_inc = 1'b0; ticks(14);
        chk("glitch_no_inc", n_inc, 0);

        // Clean press: pulse after edge DB_LIMIT+3, exactly once
        clr(); sw_dir = 1'b0;
        btn_inc = 1'b1; ticks(10); btn_inc = 1'b0; ticks(12);
        chk("clean_first_edge", first_inc, DBL + 3);
        chk("clean_n_inc", n_inc, 1);
        chk("clean_A", A, 1);
        chk("clean_B", B, 0);

        // Bouncy select press
        clr();
        btn_sel = 1'b1; ticks(2);
        btn_sel = 1'b0; ticks(1);
        btn_sel = 1'b1; ticks(3);
        btn_sel = 1'b0; ticks(1);
        btn_sel = 1'b1; ticks(10);
        btn_sel = 1'b0; ticks(12);
        chk("bounce_n_sel", n_sel, 1);
        chk("bounce_ctrl", ctrl, 1);

        // Wrap: B 0 down -> 15, then up twice -> 1; A untouched
        clr(); sw_dir = 1'b1; press_inc(8);
        chk("wrap_dn_B", B, 15);
        chk("wrap_dn_A", A, 1);
        chk("wrap_dn_n_inc", n_inc, 1);
        sw_dir = 1'b0; press_inc(8); press_inc(8);
        chk("wrap_up_B", B, 1);

        // Back to A and bring it to 5
        press_sel(8);
        chk("resel_ctrl", ctrl, 0);
        for (int i = 0; i < 4; i++) press_inc(8);
        chk("pre_sim_A", A, 5);

        // Simultaneous: step uses pre-toggle select
        clr();
        btn_sel = 1'b1; btn_inc = 1'b1; ticks(8);
        btn_sel = 1'b0; btn_inc = 1'b0; ticks(12);
        chk("sim_both", n_both, 1);
        chk("sim_n_inc", n_inc, 1);
        chk("sim_n_sel", n_sel, 1);
        chk("sim_A", A, 6);
        chk("sim_B", B, 1);
        chk("sim_ctrl", ctrl, 1);

        // Long hold on A: entry at edge 7, repeats at 27,35,43,51,59
        press_sel(8);
        clr(); btn_inc = 1'b1; ticks(63); btn_inc = 1'b0; ticks(12);
`ifdef MUX_SRC_AUTO_STEP_EN
        chk("hold_n_inc", n_inc, 6);
        chk("hold_A", A, 12);
`else
        chk("hold_n_inc", n_inc, 1);
        chk("hold_A", A, 7);
`endif
        chk("hold_B", B, 1);

        // Asynchronous reset clears state between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_A", A, 0);
        chk("async_rst_B", B, 0);
        rst_n = 1'b1;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
